// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus sequencer that replays each queued ALU command max(R,1) times
// against an internal 8-bit accumulator and pulses done after the last execution.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_op,
   input  logic [7:0]             cmd_a,
   input  logic [3:0]             cmd_reps,
   input  logic                   clear,
   output logic [7:0]             acc,
   output logic [2:0]             cur_op,
   output logic [$clog2(DEPTH):0] level,
   output logic                   busy,
   output logic                   done
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

   state_t        r_state, w_next;
   logic [14:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_level;
   logic [2:0]    r_op;
   logic [7:0]    r_a;
   logic [7:0]    r_acc;
   logic [3:0]    r_cnt;
   logic [14:0]   w_head;
   logic [7:0]    w_alu;
   logic          w_push, w_pop, w_exec;

   function automatic logic [7:0] f_ones(input logic [7:0] v);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {7'd0, v[i]};
      return n;
   endfunction

   assign w_push = cmd_valid & cmd_ready;
   assign w_pop  = (r_state == S_LOAD);
   assign w_exec = (r_state == S_EXEC);
   assign w_head = r_mem[r_rd_ptr];

   // Storage needs no reset; pointers and level define what is valid.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_reps};
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_comb begin
      case (r_op)
         3'b000:  w_alu = ~r_a ^ r_acc;
         3'b001:  w_alu = r_a ^ ~r_acc;
         3'b010:  w_alu = ~(r_a & r_acc);
         3'b011:  w_alu = r_a & r_acc;
         3'b100:  w_alu = r_a + r_acc + 8'd1;
         3'b101:  w_alu = ~(r_a ^ r_acc);
         3'b110:  w_alu = 8'd8 - f_ones(r_a);
         default: w_alu = f_ones(r_acc) + 8'd8 - f_ones(r_a);
      endcase
   end

   // clear wins over the ALU write but the repeat count keeps running.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_acc <= '0;
         r_op  <= '0;
         r_a   <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_op  <= w_head[14:12];
            r_a   <= w_head[11:4];
            r_cnt <= (w_head[3:0] == 4'd0) ? 4'd1 : w_head[3:0];
         end else if (w_exec) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (clear)       r_acc <= '0;
         else if (w_exec) r_acc <= w_alu;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_level != '0) w_next = S_LOAD;
         S_LOAD:  w_next = S_EXEC;
         S_EXEC:  if (r_cnt == 4'd1) w_next = S_DONE;
         S_DONE:  w_next = (r_level != '0) ? S_LOAD : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Gated by resetn so status reads quiet for the whole reset window.
   always_comb begin
      cmd_ready = resetn & (r_level != LVL_FULL);
      done      = resetn & (r_state == S_DONE);
      busy      = resetn & ((r_state != S_IDLE) | (r_level != '0));
      cur_op    = (resetn && r_state != S_IDLE) ? r_op : 3'd0;
      acc       = r_acc;
      level     = r_level;
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: reset, repeat timing, ALU ops, FIFO full,
// clear during execution and reset during execution.
module tb_alu_cmd_sequencer;
   logic       clock = 1'b0;
   logic       resetn, cmd_valid, cmd_ready, clear, busy, done;
   logic [2:0] cmd_op, cur_op;
   logic [7:0] cmd_a, acc;
   logic [3:0] cmd_reps;
   logic [2:0] level;

   int checks = 0;
   int errors = 0;

   // done monitor sampled on the falling edge
   logic       mon_en = 1'b0;
   int         mon_n = 0;
   int         mon_cyc = 0;
   int         mon_max_lvl = 0;
   int         mon_full_seen = 0;
   int         mon_ready_bad = 0;
   logic [7:0] log_acc [8];
   logic [2:0] log_op  [8];
   int         log_cyc [8];

   alu_cmd_sequencer #(.DEPTH(4)) dut (
      .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_reps(cmd_reps), .clear(clear),
      .acc(acc), .cur_op(cur_op), .level(level), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      mon_cyc++;
      if (mon_en) begin
         if (int'(level) > mon_max_lvl) mon_max_lvl = int'(level);
         if (level == 3'd4) mon_full_seen++;
         if (level == 3'd4 && cmd_ready) mon_ready_bad++;
         if (done) begin
            if (mon_n < 8) begin
               log_acc[mon_n] = acc;
               log_op[mon_n]  = cur_op;
               log_cyc[mon_n] = mon_cyc;
            end
            mon_n++;
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [3:0] r);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_reps = r;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic ok);
      cyc = 0; ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         tick();
         cyc++;
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic pulse_clear;
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'h05; cmd_reps = 4'd1; clear = 1'b0;
      tick(); tick();
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", acc); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
      checks++; if (done !== 1'b0 || cur_op !== 3'd0) begin errors++; $display("FAIL reset_done_op: got %b/%0d expected 0/0", done, cur_op); end
      resetn = 1'b1; cmd_valid = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", cmd_ready); end
      tick(); tick(); tick();
      checks++; if (level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL release_nocapture: got level %0d busy %b expected 0 0", level, busy); end
   endtask

   task automatic test_add_repeat;
      int cyc; logic ok;
      push(3'd4, 8'h05, 4'd1);
      wait_done(cyc, ok);
      checks++; if (!ok || cyc != 3) begin errors++; $display("FAIL add1_latency: got %0d ok %b expected 3", cyc, ok); end
      checks++; if (acc !== 8'h06) begin errors++; $display("FAIL add1_acc: got %h expected 06", acc); end
      checks++; if (cur_op !== 3'd4) begin errors++; $display("FAIL add1_curop: got %0d expected 4", cur_op); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add1_single_pulse: got done %b busy %b expected 0 0", done, busy); end
      push(3'd4, 8'h05, 4'd3);
      wait_done(cyc, ok);
      checks++; if (!ok || cyc != 5) begin errors++; $display("FAIL add3_latency: got %0d ok %b expected 5", cyc, ok); end
      checks++; if (acc !== 8'h18) begin errors++; $display("FAIL add3_acc: got %h expected 18", acc); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL add3_single_pulse: got %b expected 0", done); end
   endtask

   task automatic test_counts_wrap;
      int cyc; logic ok;
      pulse_clear();
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL clear_idle: got %h expected 00", acc); end
      push(3'd4, 8'hFF, 4'd0);
      wait_done(cyc, ok);
      checks++; if (!ok || cyc != 3) begin errors++; $display("FAIL r0_latency: got %0d ok %b expected 3", cyc, ok); end
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL wrap_acc: got %h expected 00", acc); end
      tick();
      push(3'd6, 8'h0F, 4'd1);
      wait_done(cyc, ok);
      checks++; if (!ok || acc !== 8'h04) begin errors++; $display("FAIL zeros_acc: got %h ok %b expected 04", acc, ok); end
      tick();
      push(3'd7, 8'hFF, 4'd1);
      wait_done(cyc, ok);
      checks++; if (!ok || acc !== 8'h01) begin errors++; $display("FAIL ones_zeros_acc: got %h ok %b expected 01", acc, ok); end
      tick();
   endtask

   task automatic test_fifo_full;
      logic [2:0] ops [6] = '{3'd4, 3'd3, 3'd0, 3'd2, 3'd6, 3'd7};
      logic [7:0] as  [6] = '{8'h10, 8'h0F, 8'hF0, 8'h0E, 8'h00, 8'h0F};
      logic [7:0] exp [6] = '{8'h11, 8'h01, 8'h0E, 8'hF1, 8'h08, 8'h05};
      int budget;
      pulse_clear();
      mon_n = 0; mon_max_lvl = 0; mon_full_seen = 0; mon_ready_bad = 0; mon_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cmd_valid = 1'b1; cmd_op = ops[k]; cmd_a = as[k]; cmd_reps = 4'd1;
         budget = 0;
         while (!cmd_ready && budget < 20) begin tick(); budget++; end
         tick();
      end
      cmd_valid = 1'b0;
      budget = 0;
      while (mon_n < 6 && budget < 200) begin tick(); budget++; end
      tick(); tick();
      mon_en = 1'b0;
      checks++; if (mon_n != 6) begin errors++; $display("FAIL full_done_count: got %0d expected 6", mon_n); end
      checks++; if (mon_full_seen == 0) begin errors++; $display("FAIL full_reached: got %0d cycles at level 4 expected >0", mon_full_seen); end
      checks++; if (mon_ready_bad != 0) begin errors++; $display("FAIL full_ready: got %0d cycles ready at level 4 expected 0", mon_ready_bad); end
      checks++; if (mon_max_lvl > 4) begin errors++; $display("FAIL full_max_level: got %0d expected <=4", mon_max_lvl); end
      for (int k = 0; k < 6 && k < mon_n; k++) begin
         checks++;
         if (log_acc[k] !== exp[k] || log_op[k] !== ops[k]) begin
            errors++; $display("FAIL full_order_%0d: got acc %h op %0d expected acc %h op %0d", k, log_acc[k], log_op[k], exp[k], ops[k]);
         end
      end
      for (int k = 1; k < 6 && k < mon_n; k++) begin
         checks++;
         if (log_cyc[k] - log_cyc[k-1] != 3) begin
            errors++; $display("FAIL b2b_spacing_%0d: got %0d expected 3", k, log_cyc[k] - log_cyc[k-1]);
         end
      end
   endtask

   task automatic test_clear_mid;
      pulse_clear();
      push(3'd4, 8'h01, 4'd4);
      tick();
      tick();
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL clr_exec1: got %h expected 00", acc); end
      tick();
      checks++; if (acc !== 8'h02) begin errors++; $display("FAIL clr_seq0: got %h expected 02", acc); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL clr_seq1: got %h expected 00", acc); end
      tick();
      checks++; if (acc !== 8'h02 || done !== 1'b0) begin errors++; $display("FAIL clr_seq2: got %h done %b expected 02 0", acc, done); end
      tick();
      checks++; if (acc !== 8'h04 || done !== 1'b1) begin errors++; $display("FAIL clr_seq3_done: got %h done %b expected 04 1", acc, done); end
      tick();
   endtask

   task automatic test_reset_mid;
      push(3'd4, 8'h01, 4'd3);
      push(3'd4, 8'h01, 4'd3);
      push(3'd4, 8'h01, 4'd3);
      checks++; if (cur_op !== 3'd4 || level !== 3'd2) begin errors++; $display("FAIL rstmid_setup: got op %0d level %0d expected 4 2", cur_op, level); end
      mon_n = 0; mon_en = 1'b1;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++; if (acc !== 8'h00 || level !== 3'd0) begin errors++; $display("FAIL rstmid_state: got acc %h level %0d expected 00 0", acc, level); end
      checks++; if (busy !== 1'b0 || cur_op !== 3'd0) begin errors++; $display("FAIL rstmid_idle: got busy %b op %0d expected 0 0", busy, cur_op); end
      for (int i = 0; i < 20; i++) tick();
      mon_en = 1'b0;
      checks++; if (mon_n != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", mon_n); end
   endtask

   initial begin
      test_reset();
      test_add_repeat();
      test_counts_wrap();
      test_fifo_full();
      test_clear_mid();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven front end for the 8-bit ALU/accumulator datapath. It queues operation commands (opcode, operand A, repeat count) in a small FIFO, executes each one against an internal 8-bit accumulator, and reports completion. The accumulator output feeds the existing hex display decoders and LEDs. It replaces hand-clocking the ALU register with KEY presses and sits directly upstream of the display stage.

## Interface
- DEPTH, 4, command FIFO depth in entries; power of two, 2..16
- clock  in  1  system clock, all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present on cmd_op/cmd_a/cmd_reps
- cmd_ready  out  1  FIFO can accept a command; equals ~full and is 0 while resetn=0
- cmd_op  in  3  ALU opcode
- cmd_a  in  8  operand A
- cmd_reps  in  4  repeat count R; executes max(R,1) times
- clear  in  1  synchronous accumulator clear
- acc  out  8  accumulator, which is ALU operand B
- cur_op  out  3  opcode of the command in execution; 0 when idle
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  state≠IDLE or level≠0
- done  out  1  one-cycle pulse after a command's last execution

## Operation
- A push occurs when cmd_valid & cmd_ready are both high. FIFO order is strict.
- When the FIFO is not empty, a simultaneous push and pop both take effect and leave level unchanged. When the FIFO is full, no push occurs and cmd_valid is ignored.
- ALU function, with B = acc and all results truncated to 8 bits:
  - 000: ~A^B
  - 001: A^~B
  - 010: ~(A&B)
  - 011: A&B
  - 100: A+B+1, mod 256
  - 101: ~(A^B)
  - 110: number of zero bits in A
  - 111: number of one bits in B plus number of zero bits in A
- FSM states and transitions:
  - IDLE: go to LOAD when level≠0.
  - LOAD: pop the FIFO head into op_r, a_r and cnt. cnt = R, or 1 if R=0.
  - EXEC: each cycle, acc ← alu(a_r, acc) and cnt ← cnt−1. Go to DONE when cnt=1.
  - DONE: assert done. Go to LOAD if level≠0, otherwise go to IDLE.
- clear:
  - Sets acc to 0 in any state.
  - In EXEC, clear overrides that cycle's ALU write, but cnt still decrements.
- Reset:
  - acc = 0, level = 0, state = IDLE.
  - done = 0, busy = 0, cur_op = 0, cmd_ready = 0 while resetn is low.
  - Any queued or executing commands are discarded and never produce done.
- cur_op holds op_r during LOAD, EXEC and DONE.

## Timing
- A command accepted at edge t is visible in the FIFO at t+1.
- With the FSM idle, a command accepted at edge t has this schedule:
  - LOAD during cycle t+1.
  - EXEC during cycles t+2 .. t+1+N, where N = max(R,1).
  - done high during cycle t+2+N.
- acc changes at the end of each EXEC cycle. After N executions, the final acc value is visible when done is high.
- Back-to-back commands: DONE→LOAD→EXEC, which adds 2 overhead cycles per command.
- cmd_ready is combinational from level only. It never depends on cmd_valid.
- The first cycle with resetn=1 is IDLE with cmd_ready=1.

## Test plan
- Reset: hold resetn=0 for 2 cycles with cmd_valid=1. Required: acc=0x00, level=0, busy=0, cmd_ready=0. After release, cmd_ready=1 and no command was captured.
- Add with repeat: from acc=0x00, issue op=100, A=0x05, R=1, giving acc=0x06 at done. Then issue op=100, A=0x05, R=3, giving acc=0x18 at done. Each command produces exactly one done pulse, on the cycle computed in Timing.
- Counts and wrap:
  - From acc=0x00, op=100, A=0xFF, R=0 gives acc=0x00.
  - Then op=110, A=0x0F gives acc=0x04.
  - Then op=111, A=0xFF gives acc=0x01.
- FIFO full: with DEPTH=4, push 6 commands on consecutive cycles with cmd_valid held high. Required:
  - cmd_ready deasserts when level=4.
  - All 6 commands execute in issue order.
  - 6 done pulses occur.
  - level never exceeds 4.
- Clear mid-execution: op=100, A=0x01, R=4 from acc=0x00, with clear pulsed on the 2nd EXEC cycle. Required acc sequence: 0x02, 0x00, 0x02, 0x04. done fires after 4 EXEC cycles.
- Reset mid-operation: queue 3 commands, then drop resetn for 1 cycle during the first EXEC. Required: the next cycle shows acc=0, level=0, state IDLE, and no further done pulses.
